// File: rtl/fifo_ctrl_pkg.sv
// Shared types and width constants for the FIFO write-arbiter controller.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int NREQ_DFLT = 4;
    localparam int ADDR_DFLT = 3;

    // Widths for the default configuration; the top recomputes them from its own parameters.
    localparam int ID_W    = $clog2(NREQ_DFLT);
    localparam int LEVEL_W = ADDR_DFLT + 1;

endpackage

// File: rtl/fifo_wr_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at ptr and wraps.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NREQ = NREQ_DFLT,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        gnt    = '0;
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter_ctrl.sv
// Controller for a single-clock FIFO: round-robin write sharing, gated reads,
// occupancy tracking and a flush sequence that drains the FIFO silently.
module fifo_wr_arbiter_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3,
    parameter int CELLS = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         wr_valid,
    input  logic [NREQ*WIDTH-1:0]   wr_data,
    output logic [NREQ-1:0]         wr_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    input  logic                    rd_req,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    input  logic                    flush,
    output logic                    flush_busy,
    output logic [ADDR:0]           level,
    output logic                    fifo_cs,
    output logic                    fifo_we,
    output logic                    fifo_rd,
    output logic [WIDTH-1:0]        fifo_din,
    input  logic [WIDTH-1:0]        fifo_dout,
    input  logic                    fifo_full,
    input  logic                    fifo_empty
);

    localparam int IDW = $clog2(NREQ);
    localparam int LW  = ADDR + 1;

    state_e          state_q;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q;
    logic [LW-1:0]   level_q, level_d;
    logic            rd_valid_q;
    logic            flush_busy_q;
    logic            cs_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            in_run;
    logic            in_flush;
    logic            wr_fire;

    assign in_run   = (state_q == ST_RUN);
    assign in_flush = (state_q == ST_FLUSH);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (wr_valid),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    // The full flag blocks every grant, even in a cycle that also pops a word.
    assign wr_ready = (in_run && !fifo_full) ? arb_gnt : '0;
    assign wr_fire  = |(wr_valid & wr_ready);
    assign fifo_we  = wr_fire;

    always_comb begin
        fifo_din = '0;
        if (wr_fire) begin
            fifo_din = wr_data[arb_id*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        fifo_rd = 1'b0;
        if (in_run) begin
            fifo_rd = rd_req && !fifo_empty;
        end else if (in_flush) begin
            fifo_rd = !fifo_empty;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (wr_fire) begin
            rr_ptr_d = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({wr_fire, fifo_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // state | meaning
    // INIT  | one cycle after reset, FIFO deselected, no strobes
    // RUN   | arbitrated writes and consumer reads
    // FLUSH | pop until empty, popped data is not presented
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            flush_busy_q <= 1'b0;
            cs_q         <= 1'b0;
        end else begin
            cs_q <= 1'b1;
            case (state_q)
                ST_INIT: begin
                    state_q      <= ST_RUN;
                    flush_busy_q <= 1'b0;
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q      <= ST_FLUSH;
                        flush_busy_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty && !fifo_rd) begin
                        state_q      <= ST_RUN;
                        flush_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_INIT;
                    flush_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            level_q    <= level_d;
            rd_valid_q <= fifo_rd && in_run;
            if (wr_fire) begin
                grant_id_q <= arb_id;
            end
        end
    end

    assign fifo_cs    = cs_q;
    assign grant_id   = grant_id_q;
    assign level      = level_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = fifo_dout;
    assign flush_busy = flush_busy_q;

    level_in_range: assert property (@(posedge clk) disable iff (reset)
        level_q <= LW'(CELLS));
    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(level_q == LW'(CELLS) && wr_fire && !fifo_rd));
    no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(level_q == '0 && fifo_rd && !wr_fire));

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Directed bench for fifo_wr_arbiter_ctrl with a behavioural single-clock FIFO attached.
module tb_fifo_wr_arbiter_ctrl;

    localparam int W = 8;
    localparam int A = 3;
    localparam int C = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   wr_valid;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   wr_ready;
    logic [1:0]     grant_id;
    logic           rd_req;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic           flush;
    logic           flush_busy;
    logic [A:0]     level;
    logic           fifo_cs, fifo_we, fifo_rd;
    logic [W-1:0]   fifo_din, fifo_dout;
    logic           fifo_full, fifo_empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_ctrl #(.WIDTH(W), .ADDR(A), .CELLS(C), .NREQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .grant_id   (grant_id),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .flush      (flush),
        .flush_busy (flush_busy),
        .level      (level),
        .fifo_cs    (fifo_cs),
        .fifo_we    (fifo_we),
        .fifo_rd    (fifo_rd),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    // Behavioural FIFO: registered read data, flags derived from the stored count.
    logic [W-1:0] mem [C];
    logic [A-1:0] wp, rp;
    logic [A:0]   cnt;

    assign fifo_full  = (cnt == 4'(C));
    assign fifo_empty = (cnt == 4'd0);

    always @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            fifo_dout <= '0;
        end else if (fifo_cs) begin
            if (fifo_we && !fifo_full) begin
                mem[wp] <= fifo_din;
                wp      <= wp + 1'b1;
            end
            if (fifo_rd && !fifo_empty) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 1'b1;
            end
            cnt <= cnt + 4'(fifo_we && !fifo_full) - 4'(fifo_rd && !fifo_empty);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d1 [4];
        logic [W-1:0] exp_q [$];
        int busy;
        d1 = '{8'd34, 8'd54, 8'd106, 8'd132};

        reset = 1'b1; wr_valid = 4'hf; wr_data = '0; rd_req = 1'b1; flush = 1'b0;
        tick(); tick();
        check("rst_level", 32'(level), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_flush_busy", 32'(flush_busy), 0);
        check("rst_cs", 32'(fifo_cs), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_we", 32'(fifo_we), 0);
        check("rst_rd", 32'(fifo_rd), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        reset = 1'b0; wr_valid = '0; rd_req = 1'b0;
        #1 check("init_cs", 32'(fifo_cs), 0);
        tick();
        check("run_cs", 32'(fifo_cs), 1);

        // Four writes from requester 0, then five pops with one past empty
        for (int k = 0; k < 4; k++) begin
            wr_valid = 4'b0001; wr_data = '0; wr_data[7:0] = d1[k];
            #1;
            check("t1_wr_ready", 32'(wr_ready), 1);
            check("t1_din", 32'(fifo_din), 32'(d1[k]));
            tick();
        end
        wr_valid = '0;
        check("t1_level4", 32'(level), 4);
        check("t1_grant_id", 32'(grant_id), 0);
        rd_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("t1_fifo_rd", 32'(fifo_rd), (k < 4) ? 1 : 0);
            tick();
            check("t1_rd_valid", 32'(rd_valid), (k < 4) ? 1 : 0);
            if (k < 4) check("t1_rd_data", 32'(rd_data), 32'(d1[k]));
            check("t1_level", 32'(level), (k < 4) ? 3 - k : 0);
        end
        rd_req = 1'b0;

        // All requesters contend until full
        do_reset();
        wr_valid = 4'hf;
        for (int i = 0; i < N; i++) wr_data[i*W +: W] = 8'(8'hA0 + i);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t2_wr_ready", 32'(wr_ready), 1 << (k % 4));
            check("t2_we", 32'(fifo_we), 1);
            tick();
            check("t2_grant_id", 32'(grant_id), k % 4);
            check("t2_level", 32'(level), k + 1);
        end
        #1;
        check("t2_full_ready", 32'(wr_ready), 0);
        check("t2_full_we", 32'(fifo_we), 0);
        tick();
        check("t2_full_level", 32'(level), 8);

        // Read at full blocks the write that cycle; the rr_ptr winner goes next
        rd_req = 1'b1;
        #1;
        check("t3_rd", 32'(fifo_rd), 1);
        check("t3_ready_blocked", 32'(wr_ready), 0);
        check("t3_we_blocked", 32'(fifo_we), 0);
        tick();
        check("t3_level7", 32'(level), 7);
        check("t3_rd_valid", 32'(rd_valid), 1);
        check("t3_rd_data", 32'(rd_data), 32'h0A0);
        rd_req = 1'b0;
        #1 check("t3_regrant", 32'(wr_ready), 1);
        tick();
        check("t3_level8", 32'(level), 8);
        check("t3_grant_id", 32'(grant_id), 0);
        wr_valid = '0;

        // Six writes, then a flush pulse with all requesters asking during the drain
        do_reset();
        for (int k = 0; k < 6; k++) begin
            wr_valid = 4'b0010; wr_data = '0; wr_data[15:8] = 8'(k + 1);
            tick();
        end
        wr_valid = '0; flush = 1'b1;
        tick();
        flush = 1'b0; wr_valid = 4'hf; rd_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("t4_busy", 32'(flush_busy), 1);
            check("t4_wr_ready", 32'(wr_ready), 0);
            check("t4_fifo_rd", 32'(fifo_rd), (k < 6) ? 1 : 0);
            check("t4_level", 32'(level), 6 - k);
            tick();
            check("t4_rd_valid", 32'(rd_valid), 0);
        end
        check("t4_busy_end", 32'(flush_busy), 0);
        check("t4_level_end", 32'(level), 0);
        #1 check("t4_resume_ready", 32'(wr_ready), 32'b0100);
        wr_valid = '0; rd_req = 1'b0;

        // Flush in the same cycle as a write: the write lands, drain covers it
        do_reset();
        wr_valid = 4'b0001;
        wr_data = '0; wr_data[7:0] = 8'd1; tick();
        wr_data[7:0] = 8'd2; tick();
        wr_data[7:0] = 8'd3; flush = 1'b1;
        #1 check("t5_we_with_flush", 32'(fifo_we), 1);
        tick();
        flush = 1'b0; wr_valid = '0;
        check("t5_busy", 32'(flush_busy), 1);
        check("t5_level3", 32'(level), 3);
        busy = 0;
        while (flush_busy && busy < 20) begin
            busy++;
            tick();
        end
        check("t5_busy_cycles", busy, 4);

        // Simultaneous write and read at level 3
        do_reset();
        wr_valid = 4'b0100; wr_data = '0;
        foreach (d1[k]) begin end
        for (int k = 1; k <= 3; k++) begin
            wr_data[23:16] = 8'(11 * k);
            exp_q.push_back(8'(11 * k));
            tick();
        end
        check("t6_level3", 32'(level), 3);
        rd_req = 1'b1;
        for (int k = 4; k <= 5; k++) begin
            wr_data[23:16] = 8'(11 * k);
            exp_q.push_back(8'(11 * k));
            #1;
            check("t6_we", 32'(fifo_we), 1);
            check("t6_rd", 32'(fifo_rd), 1);
            tick();
            check("t6_level_hold", 32'(level), 3);
            check("t6_rd_valid", 32'(rd_valid), 1);
            check("t6_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        wr_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_drain_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        rd_req = 1'b0;
        check("t6_level0", 32'(level), 0);

        // Reset mid-stream at level 5
        do_reset();
        wr_valid = 4'b1000; wr_data = '0;
        for (int k = 0; k < 5; k++) begin
            wr_data[31:24] = 8'(200 + k);
            tick();
        end
        check("t7_level5", 32'(level), 5);
        check("t7_grant_id3", 32'(grant_id), 3);
        reset = 1'b1; rd_req = 1'b1;
        #1 check("t7_rd_before", 32'(fifo_rd), 1);
        tick();
        check("t7_level", 32'(level), 0);
        check("t7_rd_valid", 32'(rd_valid), 0);
        check("t7_grant_id", 32'(grant_id), 0);
        check("t7_cs", 32'(fifo_cs), 0);
        check("t7_busy", 32'(flush_busy), 0);
        reset = 1'b0; flush = 1'b1;
        #1;
        check("t7_init_cs", 32'(fifo_cs), 0);
        check("t7_init_ready", 32'(wr_ready), 0);
        check("t7_init_rd", 32'(fifo_rd), 0);
        check("t7_init_we", 32'(fifo_we), 0);
        tick();
        flush = 1'b0;
        check("t7_run_cs", 32'(fifo_cs), 1);
        check("t7_flush_ignored", 32'(flush_busy), 0);
        check("t7_run_level", 32'(level), 0);
        #1;
        check("t7_empty_rd", 32'(fifo_rd), 0);
        check("t7_rr_from0", 32'(wr_ready), 32'b1000);
        wr_valid = '0;
        tick();
        check("t7_no_rd_valid", 32'(rd_valid), 0);
        rd_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
